// File: rtl/basic_loops_host_if.sv
`default_nettype none
// ============================================================================
// basic_loops_host_if : ap_ctrl_hs handshake + ap_memory port A of basic_loops
// Revision: 1.0
// ============================================================================
interface basic_loops_host_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RET_W  = 13
);
    logic              dut_ap_start;
    logic              dut_ap_done;
    logic              dut_ap_idle;
    logic              dut_ap_ready;
    logic [ADDR_W-1:0] dut_A_address0;
    logic              dut_A_ce0;
    logic [DATA_W-1:0] dut_A_q0;
    logic [RET_W-1:0]  dut_ap_return;

    // Host side owns ap_start and the RAM read data
    modport master (
        output dut_ap_start,
        output dut_A_q0,
        input  dut_ap_done,
        input  dut_ap_idle,
        input  dut_ap_ready,
        input  dut_A_address0,
        input  dut_A_ce0,
        input  dut_ap_return
    );

    modport slave (
        input  dut_ap_start,
        input  dut_A_q0,
        output dut_ap_done,
        output dut_ap_idle,
        output dut_ap_ready,
        output dut_A_address0,
        output dut_A_ce0,
        output dut_ap_return
    );
endinterface
`default_nettype wire

// File: rtl/basic_loops_host.sv
`default_nettype none
// ============================================================================
// basic_loops_host : host for HLS basic_loops - owns array A, launches runs,
// captures ap_return. Option macro: BASIC_LOOPS_HOST_CYCLE_CNT_EN (cycle_cnt).
// Revision: 1.0
// ============================================================================
module basic_loops_host #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 8,
    parameter int RET_W   = 13,
    parameter int TIMEOUT = 1023
) (
    input  wire logic              ap_clk,
    input  wire logic              ap_rst,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic              cmd_start,
    output logic                   busy,
    output logic                   result_valid,
    output logic [RET_W-1:0]       result,
    output logic                   timeout,
`ifdef BASIC_LOOPS_HOST_CYCLE_CNT_EN
    output logic [15:0]            cycle_cnt,
`endif
    basic_loops_host_if.master     bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_inc;
    logic               w_tmo_hit;
    logic               w_capture;
    logic               w_abort;
    logic               w_launch;
    logic               w_running;
    logic               r_ap_start;
    logic [RET_W-1:0]   r_result;
    logic               r_timeout;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_q0;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_unused_idle;

    assign w_unused_idle = bus.dut_ap_idle;

    assign w_running   = (r_state == S_START) || (r_state == S_WAIT);
    assign w_launch    = (r_state == S_IDLE) && cmd_start;
    assign w_timer_inc = r_timer + TMR_W'(1);
    assign w_tmo_hit   = (w_timer_inc == TMR_W'(TIMEOUT));

    // Completion beats the watchdog when both land on the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) w_state_nxt = S_START;
            end
            S_START: begin
                if (bus.dut_ap_ready && bus.dut_ap_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.dut_ap_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.dut_ap_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_timer    <= '0;
            r_ap_start <= 1'b0;
            r_result   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_launch) begin
                r_timer    <= '0;
                r_timeout  <= 1'b0;
                r_ap_start <= 1'b1;
            end else if (w_running) begin
                r_timer <= w_timer_inc;
            end
            if ((r_state == S_START && bus.dut_ap_ready) || w_abort) begin
                r_ap_start <= 1'b0;
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if (w_capture) begin
                r_result <= bus.dut_ap_return;
            end
        end
    end

`ifdef BASIC_LOOPS_HOST_CYCLE_CNT_EN
    logic [15:0] r_run_cnt;
    logic [15:0] r_cycle_cnt;
    logic [15:0] w_run_cnt_sat;

    assign w_run_cnt_sat = (r_run_cnt == 16'hFFFF) ? 16'hFFFF : r_run_cnt + 16'd1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_run_cnt   <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_run_cnt <= '0;
            end else if (w_running) begin
                r_run_cnt <= w_run_cnt_sat;
            end
            if (w_capture) begin
                r_cycle_cnt <= w_run_cnt_sat;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

    // Array A: writes only from the host while idle; out-of-range accesses ignored / read as 0
    assign w_wr_ok = (r_state == S_IDLE) && wr_en && (32'(wr_addr) < 32'(DEPTH));
    assign w_rd_ok = (32'(bus.dut_A_address0) < 32'(DEPTH));

    always_ff @(posedge ap_clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_q0 <= '0;
        end else if (bus.dut_A_ce0) begin
            r_q0 <= w_rd_ok ? r_mem[bus.dut_A_address0] : '0;
        end
    end

    assign bus.dut_ap_start = r_ap_start;
    assign bus.dut_A_q0     = r_q0;
    assign busy             = (r_state != S_IDLE);
    assign result_valid     = (r_state == S_DONE);
    assign result           = r_result;
    assign timeout          = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_basic_loops_host.sv
`default_nettype none
// ============================================================================
// tb_basic_loops_host : randomized self-checking bench; models basic_loops as
// "after ap_ready, read A[0..15] and return the sum". Revision: 1.0
// ============================================================================
module tb_basic_loops_host;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int RET_W   = 13;
    localparam int TIMEOUT = 1023;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_start;
    logic              busy, result_valid, timeout;
    logic [RET_W-1:0]  result;
    logic              busy12, result_valid12, timeout12;
    logic [RET_W-1:0]  result12;
`ifdef BASIC_LOOPS_HOST_CYCLE_CNT_EN
    logic [15:0]       cycle_cnt, cycle_cnt12;
`endif

    int                n_total = 0;
    int                n_bad   = 0;
    logic [DATA_W-1:0] shadow [16];

    always #5 ap_clk = ~ap_clk;

    basic_loops_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RET_W(RET_W)) bif ();
    basic_loops_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RET_W(RET_W)) bif12 ();

    basic_loops_host #(.ADDR_W(ADDR_W), .DEPTH(16), .DATA_W(DATA_W), .RET_W(RET_W),
                       .TIMEOUT(TIMEOUT)) u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_start(cmd_start), .busy(busy),
        .result_valid(result_valid), .result(result), .timeout(timeout),
`ifdef BASIC_LOOPS_HOST_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .bus(bif.master)
    );

    basic_loops_host #(.ADDR_W(ADDR_W), .DEPTH(12), .DATA_W(DATA_W), .RET_W(RET_W),
                       .TIMEOUT(TIMEOUT)) u_dut12 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_start(1'b0), .busy(busy12),
        .result_valid(result_valid12), .result(result12), .timeout(timeout12),
`ifdef BASIC_LOOPS_HOST_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt12),
`endif
        .bus(bif12.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    function automatic int ref_sum();
        int s = 0;
        foreach (shadow[i]) s += int'(shadow[i]);
        return s % (1 << RET_W);
    endfunction

    // One complete run against the behavioural basic_loops model
    task automatic do_run(input int ready_dly, input bit coincide, input bit poke_busy);
        int exp_sum = ref_sum();
        int sum = 0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("start_hi", bif.dut_ap_start, 1);
        chk("busy_run", busy, 1);
        chk("tmo_clr", timeout, 0);
        repeat (ready_dly) tick();
        chk("start_held", bif.dut_ap_start, 1);
        bif.dut_ap_ready = 1'b1;
        if (coincide) begin
            bif.dut_ap_done   = 1'b1;
            bif.dut_ap_return = RET_W'(exp_sum);
            tick();
            bif.dut_ap_ready = 1'b0;
            bif.dut_ap_done  = 1'b0;
            chk("start_drop", bif.dut_ap_start, 0);
        end else begin
            tick();
            bif.dut_ap_ready = 1'b0;
            chk("start_drop", bif.dut_ap_start, 0);
            bif.dut_A_address0 = '0;
            bif.dut_A_ce0      = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                tick();
                sum += int'(bif.dut_A_q0);
                wr_en = poke_busy && (i == 3); wr_addr = '0; wr_data = '0;
                if (i < 16) bif.dut_A_address0 = ADDR_W'(i);
                else        bif.dut_A_ce0 = 1'b0;
            end
            chk("ram_sum", sum, exp_sum);
            bif.dut_ap_done   = 1'b1;
            bif.dut_ap_return = RET_W'(sum);
            tick();
            bif.dut_ap_done = 1'b0;
        end
        chk("valid_hi", result_valid, 1);
        chk("result", result, exp_sum);
        tick();
        chk("valid_lo", result_valid, 0);
        chk("busy_end", busy, 0);
        chk("result_hold", result, exp_sum);
        chk("tmo_end", timeout, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit saw_valid;
        logic [RET_W-1:0] prev_res;

        ap_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cmd_start = 1'b0;
        bif.dut_ap_done = 1'b0; bif.dut_ap_idle = 1'b1; bif.dut_ap_ready = 1'b0;
        bif.dut_A_address0 = '0; bif.dut_A_ce0 = 1'b0; bif.dut_ap_return = '0;
        bif12.dut_ap_done = 1'b0; bif12.dut_ap_idle = 1'b1; bif12.dut_ap_ready = 1'b0;
        bif12.dut_A_address0 = '0; bif12.dut_A_ce0 = 1'b0; bif12.dut_ap_return = '0;
        tick(); tick();
        ap_rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_start", bif.dut_ap_start, 0);
        chk("rst_q0", bif.dut_A_q0, 0);

        // A[i] = i+1 -> sum 136
        for (int i = 0; i < 16; i++) host_write(4'(i), 8'(i + 1));
        do_run(2, 1'b0, 1'b0);

        // Direct RAM reads while idle
        bif.dut_A_address0 = 4'd5; bif.dut_A_ce0 = 1'b1;
        tick();
        chk("q0_addr5", bif.dut_A_q0, 6);
        bif.dut_A_address0 = 4'd9; bif.dut_A_ce0 = 1'b0;
        tick();
        chk("q0_hold", bif.dut_A_q0, 6);
        bif12.dut_A_address0 = 4'd15; bif12.dut_A_ce0 = 1'b1;
        tick();
        chk("q0_oob", bif12.dut_A_q0, 0);
        bif12.dut_A_address0 = 4'd11;
        tick();
        chk("q0_last12", bif12.dut_A_q0, 12);
        bif12.dut_A_ce0 = 1'b0;

        // Same-cycle write+read returns old data, next read sees new
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A;
        bif.dut_A_address0 = 4'd3; bif.dut_A_ce0 = 1'b1;
        tick();
        wr_en = 1'b0; shadow[3] = 8'h5A;
        chk("rw_same_old", bif.dut_A_q0, 4);
        tick();
        chk("rw_next_new", bif.dut_A_q0, 8'h5A);
        bif.dut_A_ce0 = 1'b0;

        // Randomized contents, ready latency and ready/done coincidence
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 1) == 1) host_write(4'(i), 8'($urandom));
            do_run(int'($urandom_range(0, 3)), r == 2, r[0]);
        end

        // All 0xFF, write attempt while busy must be ignored
        for (int i = 0; i < 16; i++) host_write(4'(i), 8'hFF);
        do_run(1, 1'b0, 1'b1);
        do_run(0, 1'b0, 1'b0);
        chk("sum4080", result, 4080);

        // Watchdog abort: ap_ready never comes
        prev_res = result;
        saw_valid = 1'b0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        cnt = 0;
        while (busy && cnt < 1100) begin
            cnt++;
            if (result_valid) saw_valid = 1'b1;
            tick();
        end
        chk("tmo_cycles", cnt, TIMEOUT);
        chk("tmo_flag", timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_start", bif.dut_ap_start, 0);
        chk("tmo_result", result, prev_res);
        chk("tmo_novalid", saw_valid, 0);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("tmo_clear", timeout, 0);
        bif.dut_ap_ready = 1'b1;
        tick();
        bif.dut_ap_ready = 1'b0;
        bif.dut_ap_done = 1'b1; bif.dut_ap_return = 13'd4080;
        tick();
        bif.dut_ap_done = 1'b0;
        chk("post_tmo_res", result, 4080);
        tick();

        // Reset in WAIT aborts the run
        host_write(4'd7, 8'h12);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        bif.dut_ap_ready = 1'b1;
        tick();
        bif.dut_ap_ready = 1'b0;
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", result_valid, 0);
        chk("mrst_result", result, 0);
        chk("mrst_start", bif.dut_ap_start, 0);
        bif.dut_ap_done = 1'b1; bif.dut_ap_return = 13'h1ABC;
        tick();
        bif.dut_ap_done = 1'b0;
        tick();
        chk("idle_done_ign", result_valid, 0);
        chk("idle_done_res", result, 0);
        do_run(1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
